// File: rtl/core_ctrl_pkg.sv
// core_ctrl_pkg: shared state encoding, halt cause codes and system instruction encodings
package core_ctrl_pkg;
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RESET  = 3'd1,
        S_RUN    = 3'd2,
        S_PAUSE  = 3'd3,
        S_STEP   = 3'd4,
        S_HALTED = 3'd5
    } state_t;
    localparam logic [1:0] CAUSE_HOST    = 2'd0;
    localparam logic [1:0] CAUSE_ECALL   = 2'd1;
    localparam logic [1:0] CAUSE_EBREAK  = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;
    localparam logic [31:0] ECALL_INSN  = 32'h0000_0073;
    localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;
endpackage

// File: rtl/core_run_ctrl_if.sv
// core_run_ctrl_if: host and core-side signals of the run controller
interface core_run_ctrl_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic             start;
    logic             step_mode;
    logic             step;
    logic             halt_req;
    logic [XLEN-1:0]  instr;
    logic             instr_valid;
    logic             core_rst_n;
    logic             core_enable;
    logic             done;
    logic [1:0]       done_cause;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] instret_count;
    logic [2:0]       state;
    modport master (
        output start, step_mode, step, halt_req, instr, instr_valid,
        input  core_rst_n, core_enable, done, done_cause, cycle_count, instret_count, state
    );
    modport slave (
        input  start, step_mode, step, halt_req, instr, instr_valid,
        output core_rst_n, core_enable, done, done_cause, cycle_count, instret_count, state
    );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: counter with synchronous clear that sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);
    // clear wins over increment; increment stops once every bit is set
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) q <= '0;
        else if (clr) q <= '0;
        else if (inc && q != '1) q <= q + 1'b1;
    end
endmodule

// File: rtl/core_run_ctrl.sv
// core_run_ctrl: sequences core reset/enable, run/step modes, counters and halt detection
module core_run_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int CNT_W      = 32,
    parameter int RST_CYCLES = 4,
    parameter int TIMEOUT    = 0
) (
    input logic            clk,
    input logic            rst,
    core_run_ctrl_if.slave bus
);
    localparam int RW = $clog2(RST_CYCLES) + 1;

    state_t           state, next_state;
    logic [RW-1:0]    rst_cnt;
    logic [1:0]       cause, halt_cause;
    logic [CNT_W-1:0] cyc, ret;
    logic             active, clr, halt, is_ecall, is_ebreak, is_tmo;

    // counters run only while the core is enabled; a new run clears them on the start edge
    always_comb begin
        active     = state == S_RUN || state == S_STEP;
        clr        = (state == S_IDLE || state == S_HALTED) && bus.start;
        is_ecall   = bus.instr_valid && bus.instr == XLEN'(ECALL_INSN);
        is_ebreak  = bus.instr_valid && bus.instr == XLEN'(EBREAK_INSN);
        is_tmo     = TIMEOUT != 0 && cyc == CNT_W'(TIMEOUT - 1);
        halt       = active && (is_ecall || is_ebreak || is_tmo || bus.halt_req);
        halt_cause = is_ecall ? CAUSE_ECALL : is_ebreak ? CAUSE_EBREAK :
                     is_tmo ? CAUSE_TIMEOUT : CAUSE_HOST;
    end

    sat_counter #(.W(CNT_W)) u_cycle (
        .clk(clk), .rst(rst), .clr(clr), .inc(active), .q(cyc)
    );

    sat_counter #(.W(CNT_W)) u_instret (
        .clk(clk), .rst(rst), .clr(clr), .inc(active && bus.instr_valid), .q(ret)
    );

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else state <= next_state;
    end

    // cycles spent so far in RESET
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_cnt <= '0;
        else rst_cnt <= (state == S_RESET) ? rst_cnt + 1'b1 : '0;
    end

    // halt cause latched when the run stops, cleared when a new run starts
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cause <= CAUSE_HOST;
        else if (clr) cause <= CAUSE_HOST;
        else if (halt) cause <= halt_cause;
    end

    // next-state decode; step beats a step_mode drop in PAUSE
    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE, S_HALTED: if (bus.start) next_state = S_RESET;
            S_RESET: if (rst_cnt == RW'(RST_CYCLES - 1)) next_state = bus.step_mode ? S_PAUSE : S_RUN;
            S_RUN:   if (halt) next_state = S_HALTED;
            S_PAUSE: next_state = bus.step ? S_STEP : bus.step_mode ? S_PAUSE : S_RUN;
            S_STEP:  next_state = halt ? S_HALTED : S_PAUSE;
            default: next_state = S_IDLE;
        endcase
    end

    // Moore outputs decoded from registered state
    always_comb begin
        bus.core_rst_n    = !(state == S_IDLE || state == S_RESET);
        bus.core_enable   = active;
        bus.done          = state == S_HALTED;
        bus.done_cause    = cause;
        bus.cycle_count   = cyc;
        bus.instret_count = ret;
        bus.state         = state;
    end
endmodule

// File: tb/tb_core_run_ctrl.sv
// tb_core_run_ctrl: directed scenario bench for the run controller
module tb_core_run_ctrl;
    import core_ctrl_pkg::*;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    core_run_ctrl_if #(.XLEN(32), .CNT_W(4))  bus0 ();
    core_run_ctrl_if #(.XLEN(32), .CNT_W(32)) bus1 ();

    core_run_ctrl #(.XLEN(32), .CNT_W(4), .RST_CYCLES(4), .TIMEOUT(0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );

    core_run_ctrl #(.XLEN(32), .CNT_W(32), .RST_CYCLES(4), .TIMEOUT(20)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        n_checks++; if (bus0.state !== 3'(S_IDLE)) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", bus0.state, S_IDLE); end
        n_checks++; if (bus0.core_rst_n !== 1'b0) begin n_fail++; $display("FAIL reset_core_rst_n: got %b expected 0", bus0.core_rst_n); end
        n_checks++; if (bus0.core_enable !== 1'b0) begin n_fail++; $display("FAIL reset_core_enable: got %b expected 0", bus0.core_enable); end
        n_checks++; if (bus0.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus0.done); end
        n_checks++; if (bus0.done_cause !== 2'd0) begin n_fail++; $display("FAIL reset_cause: got %0d expected 0", bus0.done_cause); end
        n_checks++; if (bus0.cycle_count !== 4'd0 || bus0.instret_count !== 4'd0) begin n_fail++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", bus0.cycle_count, bus0.instret_count); end
        n_checks++; if (bus1.state !== 3'(S_IDLE) || bus1.cycle_count !== 32'd0) begin n_fail++; $display("FAIL reset_dut1: got state %0d cycles %0d expected 0/0", bus1.state, bus1.cycle_count); end
        tick();
        rst = 1'b1;
        tick();
        n_checks++; if (bus0.state !== 3'(S_IDLE) || bus0.core_rst_n !== 1'b0) begin n_fail++; $display("FAIL idle_hold: got state %0d rst_n %b expected 0/0", bus0.state, bus0.core_rst_n); end
    endtask

    task automatic test_start_timing();
        bus0.step_mode = 1'b0;
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (bus0.state !== 3'(S_RESET) || bus0.core_rst_n !== 1'b0 || bus0.core_enable !== 1'b0) begin n_fail++; $display("FAIL reset_phase_%0d: got state %0d rst_n %b en %b expected %0d/0/0", i, bus0.state, bus0.core_rst_n, bus0.core_enable, S_RESET); end
            tick();
        end
        n_checks++; if (bus0.state !== 3'(S_RUN) || bus0.core_rst_n !== 1'b1 || bus0.core_enable !== 1'b1) begin n_fail++; $display("FAIL run_entry: got state %0d rst_n %b en %b expected %0d/1/1", bus0.state, bus0.core_rst_n, bus0.core_enable, S_RUN); end
    endtask

    task automatic test_ecall();
        for (int i = 1; i <= 10; i++) begin
            bus0.instr_valid = 1'b1;
            bus0.instr = (i == 10) ? ECALL : NOP;
            tick();
            if (i == 9) begin
                n_checks++; if (bus0.done !== 1'b0 || bus0.core_enable !== 1'b1) begin n_fail++; $display("FAIL ecall_early: got done %b en %b expected 0/1", bus0.done, bus0.core_enable); end
            end
        end
        bus0.instr_valid = 1'b0;
        n_checks++; if (bus0.done !== 1'b1 || bus0.core_enable !== 1'b0) begin n_fail++; $display("FAIL ecall_halt: got done %b en %b expected 1/0", bus0.done, bus0.core_enable); end
        n_checks++; if (bus0.done_cause !== 2'd1) begin n_fail++; $display("FAIL ecall_cause: got %0d expected 1", bus0.done_cause); end
        n_checks++; if (bus0.instret_count !== 4'd10 || bus0.cycle_count !== 4'd10) begin n_fail++; $display("FAIL ecall_counts: got %0d/%0d expected 10/10", bus0.instret_count, bus0.cycle_count); end
        bus0.instr_valid = 1'b1;
        bus0.instr = NOP;
        bus0.step = 1'b1;
        repeat (3) tick();
        bus0.instr_valid = 1'b0;
        bus0.step = 1'b0;
        n_checks++; if (bus0.state !== 3'(S_HALTED) || bus0.instret_count !== 4'd10 || bus0.done_cause !== 2'd1) begin n_fail++; $display("FAIL halted_hold: got state %0d instret %0d cause %0d expected %0d/10/1", bus0.state, bus0.instret_count, bus0.done_cause, S_HALTED); end
    endtask

    task automatic test_step();
        int pulses = 0;
        bus0.step_mode = 1'b1;
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        n_checks++; if (bus0.instret_count !== 4'd0 || bus0.cycle_count !== 4'd0 || bus0.done_cause !== 2'd0 || bus0.done !== 1'b0) begin n_fail++; $display("FAIL restart_clear: got instret %0d cycles %0d cause %0d done %b expected 0/0/0/0", bus0.instret_count, bus0.cycle_count, bus0.done_cause, bus0.done); end
        repeat (4) tick();
        n_checks++; if (bus0.state !== 3'(S_PAUSE) || bus0.core_rst_n !== 1'b1 || bus0.core_enable !== 1'b0) begin n_fail++; $display("FAIL pause_entry: got state %0d rst_n %b en %b expected %0d/1/0", bus0.state, bus0.core_rst_n, bus0.core_enable, S_PAUSE); end
        bus0.instr_valid = 1'b1;
        bus0.instr = NOP;
        repeat (2) tick();
        n_checks++; if (bus0.instret_count !== 4'd0 || bus0.cycle_count !== 4'd0) begin n_fail++; $display("FAIL pause_frozen: got %0d/%0d expected 0/0", bus0.instret_count, bus0.cycle_count); end
        for (int k = 1; k <= 3; k++) begin
            bus0.instr = (k == 3) ? EBREAK : NOP;
            bus0.step = 1'b1;
            tick();
            bus0.step = 1'b0;
            pulses += int'(bus0.core_enable);
            n_checks++; if (bus0.core_enable !== 1'b1) begin n_fail++; $display("FAIL step_%0d_on: got en %b expected 1", k, bus0.core_enable); end
            tick();
            pulses += int'(bus0.core_enable);
            n_checks++; if (bus0.core_enable !== 1'b0) begin n_fail++; $display("FAIL step_%0d_off: got en %b expected 0", k, bus0.core_enable); end
            tick();
            pulses += int'(bus0.core_enable);
        end
        bus0.instr_valid = 1'b0;
        n_checks++; if (pulses !== 3) begin n_fail++; $display("FAIL step_pulses: got %0d expected 3", pulses); end
        n_checks++; if (bus0.done !== 1'b1 || bus0.done_cause !== 2'd2) begin n_fail++; $display("FAIL step_ebreak: got done %b cause %0d expected 1/2", bus0.done, bus0.done_cause); end
        n_checks++; if (bus0.instret_count !== 4'd3 || bus0.cycle_count !== 4'd3) begin n_fail++; $display("FAIL step_counts: got %0d/%0d expected 3/3", bus0.instret_count, bus0.cycle_count); end
    endtask

    task automatic test_saturate();
        bus0.step_mode = 1'b0;
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        n_checks++; if (bus0.state !== 3'(S_RESET) || bus0.instret_count !== 4'd0 || bus0.done_cause !== 2'd0) begin n_fail++; $display("FAIL sat_restart: got state %0d instret %0d cause %0d expected %0d/0/0", bus0.state, bus0.instret_count, bus0.done_cause, S_RESET); end
        repeat (4) tick();
        bus0.instr_valid = 1'b1;
        bus0.instr = NOP;
        repeat (20) tick();
        bus0.instr_valid = 1'b0;
        n_checks++; if (bus0.done !== 1'b0 || bus0.instret_count !== 4'd15) begin n_fail++; $display("FAIL sat_running: got done %b instret %0d expected 0/15", bus0.done, bus0.instret_count); end
        bus0.halt_req = 1'b1;
        tick();
        bus0.halt_req = 1'b0;
        n_checks++; if (bus0.done !== 1'b1 || bus0.done_cause !== 2'd0) begin n_fail++; $display("FAIL sat_halt: got done %b cause %0d expected 1/0", bus0.done, bus0.done_cause); end
        n_checks++; if (bus0.instret_count !== 4'd15 || bus0.cycle_count !== 4'd15) begin n_fail++; $display("FAIL sat_counts: got %0d/%0d expected 15/15", bus0.instret_count, bus0.cycle_count); end
    endtask

    task automatic test_timeout();
        bus1.step_mode = 1'b0;
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        repeat (4) tick();
        repeat (19) tick();
        n_checks++; if (bus1.done !== 1'b0 || bus1.cycle_count !== 32'd19) begin n_fail++; $display("FAIL timeout_early: got done %b cycles %0d expected 0/19", bus1.done, bus1.cycle_count); end
        tick();
        n_checks++; if (bus1.done !== 1'b1 || bus1.done_cause !== 2'd3 || bus1.core_enable !== 1'b0) begin n_fail++; $display("FAIL timeout_halt: got done %b cause %0d en %b expected 1/3/0", bus1.done, bus1.done_cause, bus1.core_enable); end
        n_checks++; if (bus1.cycle_count !== 32'd20 || bus1.instret_count !== 32'd0) begin n_fail++; $display("FAIL timeout_counts: got %0d/%0d expected 20/0", bus1.cycle_count, bus1.instret_count); end
    endtask

    task automatic test_ebreak_timeout();
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        repeat (4) tick();
        for (int i = 1; i <= 20; i++) begin
            bus1.instr_valid = 1'b1;
            bus1.instr = (i == 20) ? EBREAK : NOP;
            tick();
        end
        bus1.instr_valid = 1'b0;
        n_checks++; if (bus1.done !== 1'b1 || bus1.done_cause !== 2'd2) begin n_fail++; $display("FAIL ebreak_vs_timeout: got done %b cause %0d expected 1/2", bus1.done, bus1.done_cause); end
        n_checks++; if (bus1.cycle_count !== 32'd20 || bus1.instret_count !== 32'd20) begin n_fail++; $display("FAIL ebreak_counts: got %0d/%0d expected 20/20", bus1.cycle_count, bus1.instret_count); end
    endtask

    task automatic test_async_reset();
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        repeat (4) tick();
        bus0.instr_valid = 1'b1;
        bus0.instr = NOP;
        repeat (3) tick();
        n_checks++; if (bus0.core_enable !== 1'b1 || bus0.instret_count !== 4'd3) begin n_fail++; $display("FAIL async_pre: got en %b instret %0d expected 1/3", bus0.core_enable, bus0.instret_count); end
        #2;
        rst = 1'b0;
        #1;
        n_checks++; if (bus0.state !== 3'(S_IDLE) || bus0.core_rst_n !== 1'b0 || bus0.core_enable !== 1'b0) begin n_fail++; $display("FAIL async_ctrl: got state %0d rst_n %b en %b expected 0/0/0", bus0.state, bus0.core_rst_n, bus0.core_enable); end
        n_checks++; if (bus0.instret_count !== 4'd0 || bus0.cycle_count !== 4'd0 || bus1.done !== 1'b0 || bus1.done_cause !== 2'd0) begin n_fail++; $display("FAIL async_clear: got instret %0d cycles %0d done1 %b cause1 %0d expected 0/0/0/0", bus0.instret_count, bus0.cycle_count, bus1.done, bus1.done_cause); end
        bus0.instr_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        n_checks++; if (bus0.state !== 3'(S_IDLE)) begin n_fail++; $display("FAIL async_release: got state %0d expected 0", bus0.state); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus0.start = 1'b0; bus0.step_mode = 1'b0; bus0.step = 1'b0; bus0.halt_req = 1'b0;
        bus0.instr = '0; bus0.instr_valid = 1'b0;
        bus1.start = 1'b0; bus1.step_mode = 1'b0; bus1.step = 1'b0; bus1.halt_req = 1'b0;
        bus1.instr = '0; bus1.instr_valid = 1'b0;
        test_reset();
        test_start_timing();
        test_ecall();
        test_step();
        test_saturate();
        test_timeout();
        test_ebreak_timeout();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
